// File: rtl/io_port_bank_pkg.sv
// Shared address-map defaults and decode helpers for the memory-mapped I/O port bank.
// The decoder reports which window an address falls in and the offset within it.
package io_pkg;

    localparam int unsigned OUT_BASE_DEF = 32'hE0;
    localparam int unsigned IN_BASE_DEF  = 32'hF0;
    localparam int unsigned IRQ_BASE_DEF = 32'hD0;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_IN,
        SEL_IRQ
    } sel_e;

    // Offset is wide enough for the largest IRQ window (2 * 64 one-bit bytes).
    typedef struct packed {
        sel_e       sel;
        logic [6:0] idx;
    } decode_t;

    function automatic int unsigned nb_bytes(input int unsigned n, input int unsigned w);
        return (n + w - 1) / w;
    endfunction

    function automatic bit in_window(input int unsigned addr, input int unsigned base,
                                     input int unsigned n);
        return (addr >= base) && (addr < base + n);
    endfunction

    function automatic bit windows_overlap(input int unsigned a, input int unsigned na,
                                           input int unsigned b, input int unsigned nb);
        return (a < b + nb) && (b < a + na);
    endfunction

    function automatic decode_t decode(input int unsigned addr,
                                       input int unsigned out_base,
                                       input int unsigned in_base,
                                       input int unsigned irq_base,
                                       input int unsigned n_ports,
                                       input int unsigned irq_span);
        decode_t d;
        d.sel = SEL_NONE;
        d.idx = '0;
        if (in_window(addr, out_base, n_ports)) begin
            d.sel = SEL_OUT;
            d.idx = 7'(addr - out_base);
        end else if (in_window(addr, in_base, n_ports)) begin
            d.sel = SEL_IN;
            d.idx = 7'(addr - in_base);
        end else if (irq_span != 0 && in_window(addr, irq_base, irq_span)) begin
            d.sel = SEL_IRQ;
            d.idx = 7'(addr - irq_base);
        end
        return d;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// CPU-side bus of the I/O port bank: address, write data, write strobe and registered read data.
interface io_port_bank_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              write;
    logic [DATA_W-1:0] data_out;

    modport master (output address, output data_in, output write, input data_out);
    modport slave  (input address, input data_in, input write, output data_out);
endinterface

// File: rtl/io_port_bank_sync.sv
// Multi-flop input synchroniser with asynchronous reset; all bits share the same chain depth.
module io_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset) stage_q[gi] <= '0;
                else       stage_q[gi] <= d_i;
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
                if (reset) stage_q[gi] <= '0;
                else       stage_q[gi] <= stage_q[gi-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of registered output ports and synchronised input ports with registered reads.
// Optional per-port change interrupts are enabled by defining IO_IRQ_EN.
module io_port_bank
    import io_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned N_PORTS     = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned OUT_BASE    = OUT_BASE_DEF,
    parameter int unsigned IN_BASE     = IN_BASE_DEF,
    parameter int unsigned IRQ_BASE    = IRQ_BASE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    io_port_bank_if.slave               bus,
    input  logic [N_PORTS*DATA_W-1:0]   port_in,
    output logic [N_PORTS*DATA_W-1:0]   port_out,
    output logic                        irq
);

`ifdef IO_IRQ_EN
    localparam int unsigned NB       = nb_bytes(N_PORTS, DATA_W);
    localparam int unsigned IRQ_SPAN = 2 * NB;
`else
    localparam int unsigned IRQ_SPAN = 0;
`endif

    if (N_PORTS < 1 || N_PORTS > 64) begin : g_err_nports
        $error("io_port_bank: N_PORTS must be 1..64");
    end
    if (SYNC_STAGES < 2) begin : g_err_sync
        $error("io_port_bank: SYNC_STAGES must be at least 2");
    end
    if (windows_overlap(OUT_BASE, N_PORTS, IN_BASE, N_PORTS)) begin : g_err_ovl_io
        $error("io_port_bank: output and input windows overlap");
    end
    if (64'(OUT_BASE) + 64'(N_PORTS) > (64'd1 << ADDR_W) ||
        64'(IN_BASE) + 64'(N_PORTS) > (64'd1 << ADDR_W)) begin : g_err_wrap_io
        $error("io_port_bank: port window wraps past the top of the address space");
    end
`ifdef IO_IRQ_EN
    if (windows_overlap(IRQ_BASE, IRQ_SPAN, OUT_BASE, N_PORTS) ||
        windows_overlap(IRQ_BASE, IRQ_SPAN, IN_BASE, N_PORTS)) begin : g_err_ovl_irq
        $error("io_port_bank: IRQ window overlaps a port window");
    end
    if (64'(IRQ_BASE) + 64'(IRQ_SPAN) > (64'd1 << ADDR_W)) begin : g_err_wrap_irq
        $error("io_port_bank: IRQ window wraps past the top of the address space");
    end
`endif

    decode_t                    dec;
    logic [N_PORTS*DATA_W-1:0]  sync_vec;
    logic [DATA_W-1:0]          sync_arr [N_PORTS];
    logic [DATA_W-1:0]          port_q   [N_PORTS];
    logic [DATA_W-1:0]          rdata_d;
    logic [DATA_W-1:0]          rdata_q;

    assign dec = decode(32'(bus.address), OUT_BASE, IN_BASE, IRQ_BASE, N_PORTS, IRQ_SPAN);

    io_sync #(
        .WIDTH  (N_PORTS * DATA_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (port_in),
        .q_o   (sync_vec)
    );

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign sync_arr[gi] = sync_vec[gi*DATA_W +: DATA_W];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                port_q[gi] <= '0;
            end else if (bus.write && dec.sel == SEL_OUT && dec.idx == 7'(gi)) begin
                port_q[gi] <= bus.data_in;
            end
        end

        assign port_out[gi*DATA_W +: DATA_W] = port_q[gi];
    end

`ifdef IO_IRQ_EN
    logic [DATA_W-1:0]          sync_prev_q [N_PORTS];
    logic [N_PORTS-1:0]         change;
    logic [N_PORTS-1:0]         pending_q, pending_d;
    logic [N_PORTS-1:0]         mask_q, mask_d;
    logic [NB*DATA_W-1:0]       pend_pad, mask_pad, clr_pad, mask_wr_pad;
    logic [DATA_W-1:0]          irq_rd [IRQ_SPAN];
    logic                       irq_q, irq_d;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_det
        always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_prev_q[gi] <= '0;
            else       sync_prev_q[gi] <= sync_arr[gi];
        end
        assign change[gi] = |(sync_arr[gi] ^ sync_prev_q[gi]);
    end

    // Pending and mask live in byte-sized registers; bits above N_PORTS read as zero.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[N_PORTS-1:0]    = pending_q;
        mask_pad                 = '0;
        mask_pad[N_PORTS-1:0]    = mask_q;
        clr_pad                  = '0;
        mask_wr_pad              = mask_pad;
        for (int i = 0; i < NB; i++) begin
            irq_rd[i]      = pend_pad[i*DATA_W +: DATA_W];
            irq_rd[NB + i] = mask_pad[i*DATA_W +: DATA_W];
            if (bus.write && dec.sel == SEL_IRQ) begin
                if (dec.idx == 7'(i))      clr_pad[i*DATA_W +: DATA_W]     = bus.data_in;
                if (dec.idx == 7'(NB + i)) mask_wr_pad[i*DATA_W +: DATA_W] = bus.data_in;
            end
        end
        // A new change outranks a simultaneous write-1-to-clear.
        pending_d = (pending_q & ~clr_pad[N_PORTS-1:0]) | change;
        mask_d    = mask_wr_pad[N_PORTS-1:0];
        irq_d     = |(pending_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Register file is read before this edge's write lands, so a same-cycle access sees old data.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (dec.idx == 7'(k)) begin
                if (dec.sel == SEL_OUT) rdata_d = port_q[k];
                if (dec.sel == SEL_IN)  rdata_d = sync_arr[k];
            end
        end
`ifdef IO_IRQ_EN
        for (int i = 0; i < IRQ_SPAN; i++) begin
            if (dec.sel == SEL_IRQ && dec.idx == 7'(i)) rdata_d = irq_rd[i];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign bus.data_out = rdata_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: an 8-bit/16-port instance and a 16-bit/4-port instance.
module tb_io_port_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] pin8;
    logic [127:0] pout8;
    logic         irq8;
    logic [63:0]  pin16;
    logic [63:0]  pout16;
    logic         irq16;

    int tests = 0;
    int fails = 0;

    io_port_bank_if #(.ADDR_W(8), .DATA_W(8))  bus8 ();
    io_port_bank_if #(.ADDR_W(8), .DATA_W(16)) bus16 ();

    io_port_bank #(.DATA_W(8), .N_PORTS(16), .ADDR_W(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus8),
        .port_in  (pin8),
        .port_out (pout8),
        .irq      (irq8)
    );

    io_port_bank #(.DATA_W(16), .N_PORTS(4), .ADDR_W(8)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus16),
        .port_in  (pin16),
        .port_out (pout16),
        .irq      (irq16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_dout;
        int         pidx;
        logic [7:0] exp_port;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bus8.write   = we;
        bus8.address = addr;
        bus8.data_in = wdata;
    endtask

    task automatic drive16(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
        bus16.write   = we;
        bus16.address = addr;
        bus16.data_in = wdata;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    logic [127:0] exp_all;

    initial begin
        vecs[0]  = '{1'b1, 8'hE5, 8'h3C, 8'h00, 5,  8'h3C};
        vecs[1]  = '{1'b0, 8'hE5, 8'h00, 8'h3C, 5,  8'h3C};
        vecs[2]  = '{1'b0, 8'hE4, 8'h00, 8'h00, 4,  8'h00};
        vecs[3]  = '{1'b0, 8'hF3, 8'h00, 8'hA5, 5,  8'h3C};
        vecs[4]  = '{1'b1, 8'hE0, 8'h11, 8'h00, 0,  8'h11};
        vecs[5]  = '{1'b1, 8'hE0, 8'h55, 8'h11, 0,  8'h55};
        vecs[6]  = '{1'b0, 8'hE0, 8'h00, 8'h55, 0,  8'h55};
        vecs[7]  = '{1'b0, 8'h10, 8'h00, 8'h00, 0,  8'h55};
        vecs[8]  = '{1'b1, 8'hFF, 8'h99, 8'hA5, 15, 8'h00};
        vecs[9]  = '{1'b1, 8'h10, 8'h66, 8'h00, 0,  8'h55};
        vecs[10] = '{1'b0, 8'hEF, 8'h00, 8'h00, 15, 8'h00};
        vecs[11] = '{1'b1, 8'hEF, 8'hC3, 8'h00, 15, 8'hC3};
        vecs[12] = '{1'b0, 8'hEF, 8'h00, 8'hC3, 15, 8'hC3};
        vecs[13] = '{1'b0, 8'hDF, 8'h00, 8'h00, 15, 8'hC3};
        vecs[14] = '{1'b0, 8'hF0, 8'h00, 8'hA5, 6,  8'h00};

        reset = 1'b1;
        pin8  = {16{8'hA5}};
        pin16 = '0;
        drive8(1'b0, 8'h00, 8'h00);
        drive16(1'b0, 8'h00, 16'h0000);

        // Reset held with active pins
        repeat (3) tick();
        chk("reset port_out", pout8, 128'h0);
        chk("reset data_out", {120'h0, bus8.data_out}, 128'h0);
        chk("reset irq", {127'h0, irq8}, 128'h0);
        chk("reset port_out16", {64'h0, pout16}, 128'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a write cycle
        drive8(1'b1, 8'hE6, 8'h77);
        tick();
        chk("pre-reset write E6", {120'h0, pout8[48 +: 8]}, {120'h0, 8'h77});
        drive8(1'b1, 8'hE5, 8'h3C);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset port_out", pout8, 128'h0);
        chk("async reset data_out", {120'h0, bus8.data_out}, 128'h0);
        tick();
        reset = 1'b0;
        drive8(1'b0, 8'h00, 8'h00);
        tick();
        chk("write lost across reset", pout8, 128'h0);
        repeat (3) tick();

        // Table of single-cycle accesses
        for (int i = 0; i < 15; i++) begin
            drive8(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d addr %0h data_out", i, vecs[i].addr),
                {120'h0, bus8.data_out}, {120'h0, vecs[i].exp_dout});
            chk($sformatf("vec%0d port_out[%0d]", i, vecs[i].pidx),
                {120'h0, pout8[vecs[i].pidx*8 +: 8]}, {120'h0, vecs[i].exp_port});
        end
        exp_all          = '0;
        exp_all[0 +: 8]  = 8'h55;
        exp_all[40 +: 8] = 8'h3C;
        exp_all[120 +: 8]= 8'hC3;
        chk("port_out full vector", pout8, exp_all);

        // Input latency: pin change visible on data_out on the third edge
        pin8[120 +: 8] = 8'h81;
        drive8(1'b0, 8'hFF, 8'h00);
        tick();
        tick();
        chk("input latency edge2", {120'h0, bus8.data_out}, {120'h0, 8'hA5});
        tick();
        chk("input latency edge3", {120'h0, bus8.data_out}, {120'h0, 8'h81});

`ifdef IO_IRQ_EN
        // Drain the changes from reset release, then arm port 2 only
        drive8(1'b1, 8'hD0, 8'hFF);
        tick();
        drive8(1'b1, 8'hD1, 8'hFF);
        tick();
        drive8(1'b1, 8'hD2, 8'h04);
        tick();
        drive8(1'b0, 8'hD0, 8'h00);
        tick();
        tick();
        chk("irq idle", {127'h0, irq8}, 128'h0);
        chk("pending cleared", {120'h0, bus8.data_out}, 128'h0);
        drive8(1'b0, 8'hD2, 8'h00);
        tick();
        chk("mask readback", {120'h0, bus8.data_out}, {120'h0, 8'h04});

        pin8[16 +: 8] = 8'hA4;
        drive8(1'b0, 8'hD0, 8'h00);
        repeat (5) tick();
        chk("pending after toggle", {120'h0, bus8.data_out}, {120'h0, 8'h04});
        chk("irq after toggle", {127'h0, irq8}, 128'h1);

        drive8(1'b1, 8'hD0, 8'h04);
        tick();
        chk("irq one cycle after clear", {127'h0, irq8}, 128'h1);
        drive8(1'b0, 8'hD0, 8'h00);
        tick();
        chk("irq two cycles after clear", {127'h0, irq8}, 128'h0);
        chk("pending after clear", {120'h0, bus8.data_out}, 128'h0);

        // Change detection and clear land on the same edge: set wins
        pin8[16 +: 8] = 8'hA5;
        tick();
        tick();
        drive8(1'b1, 8'hD0, 8'h04);
        tick();
        drive8(1'b0, 8'hD0, 8'h00);
        tick();
        chk("set wins over clear", {120'h0, bus8.data_out}, {120'h0, 8'h04});
        chk("irq after set wins", {127'h0, irq8}, 128'h1);
`else
        pin8[16 +: 8] = 8'hA4;
        drive8(1'b0, 8'hD0, 8'h00);
        repeat (5) tick();
        chk("irq window reads 0", {120'h0, bus8.data_out}, 128'h0);
        chk("irq tied low", {127'h0, irq8}, 128'h0);
`endif

        // Wide-port, 4-port instance
        drive8(1'b0, 8'h00, 8'h00);
        drive16(1'b1, 8'hE3, 16'hBEEF);
        tick();
        chk("w16 port_out[3]", {112'h0, pout16[48 +: 16]}, {112'h0, 16'hBEEF});
        drive16(1'b1, 8'hE4, 16'h1234);
        tick();
        chk("w16 E4 write ignored", {64'h0, pout16}, {64'h0, 16'hBEEF, 48'h0});
        chk("w16 E4 reads 0", {112'h0, bus16.data_out}, 128'h0);
        drive16(1'b0, 8'hE3, 16'h0000);
        tick();
        chk("w16 E3 readback", {112'h0, bus16.data_out}, {112'h0, 16'hBEEF});
        pin16[48 +: 16] = 16'hCAFE;
        drive16(1'b0, 8'hF3, 16'h0000);
        repeat (3) tick();
        chk("w16 input F3", {112'h0, bus16.data_out}, {112'h0, 16'hCAFE});
        drive16(1'b0, 8'hF4, 16'h0000);
        tick();
        chk("w16 F4 unmapped", {112'h0, bus16.data_out}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
